// File: rtl/instr_mem_loadable.sv
// Loadable synchronous instruction memory for the MIPS core: a sequential
// program-load port with an auto-incrementing pointer, and a registered fetch port.
module instr_mem_loadable #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 6,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  input  logic          fetch_req,
  input  logic [31:0]   pc,
  output logic          ready,
  output logic [AW:0]   prog_len,
  output logic          load_err,
  output logic          fetch_valid,
  output logic          fetch_fault,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    func,
  output logic [15:0]   imm,
  output logic [25:0]   jtarget
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  logic [31:0] mem [DEPTH];

  state_t      state_r;
  state_t      state_next_s;
  logic [AW:0] ptr_r;
  logic [AW:0] ptr_next_s;
  logic        load_err_r;
  logic        load_err_next_s;
  logic        wr_en_s;
  logic        fetch_valid_r;
  logic        fetch_fault_r;
  logic [31:0] instr_r;
  logic        fetch_bad_s;
  logic [AW-1:0] fetch_idx_s;

  // Next-state, write-pointer and error-flag logic for the load sequencer.
  always_comb begin
    state_next_s    = state_r;
    ptr_next_s      = ptr_r;
    load_err_next_s = load_err_r;
    wr_en_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_start) begin
          state_next_s    = LOAD;
          ptr_next_s      = {(AW+1){1'b0}};
          load_err_next_s = 1'b0;
        end else begin
          state_next_s    = IDLE;
        end
      end
      LOAD: begin
        if (load_start) begin
          // Restart dominates any word presented in the same cycle.
          ptr_next_s      = {(AW+1){1'b0}};
          load_err_next_s = 1'b0;
        end else if (load_valid) begin
          if (ptr_r < DEPTH_W) begin
            wr_en_s    = 1'b1;
            ptr_next_s = ptr_r + ONE_W;
          end else begin
            load_err_next_s = 1'b1;
          end
          if (load_last) begin
            state_next_s = RUN;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      RUN: begin
        if (load_start) begin
          state_next_s    = LOAD;
          ptr_next_s      = {(AW+1){1'b0}};
          load_err_next_s = 1'b0;
        end else begin
          state_next_s    = RUN;
        end
      end
      default: begin
        state_next_s    = IDLE;
        ptr_next_s      = {(AW+1){1'b0}};
        load_err_next_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, write pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {(AW+1){1'b0}};
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ptr_r      <= ptr_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  // Program store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[ptr_r[AW-1:0]] <= load_data;
    end
  end

  assign fetch_idx_s = pc[AW+1:2];
  assign fetch_bad_s = (pc[1:0] != 2'b00) || (|pc[31:AW+2]);

  // Registered fetch port; instr holds its value on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_r <= 1'b0;
      fetch_fault_r <= 1'b0;
      instr_r       <= 32'h00000000;
    end else if ((state_r == RUN) && fetch_req) begin
      fetch_valid_r <= 1'b1;
      fetch_fault_r <= fetch_bad_s;
      instr_r       <= fetch_bad_s ? NOP : mem[fetch_idx_s];
    end else begin
      fetch_valid_r <= 1'b0;
      fetch_fault_r <= 1'b0;
    end
  end

  assign ready       = (state_r == RUN);
  assign prog_len    = ptr_r;
  assign load_err    = load_err_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_fault = fetch_fault_r;
  assign instr       = instr_r;
  // Pure slices; sign extension of imm happens downstream.
  assign opcode      = instr_r[31:26];
  assign rs          = instr_r[25:21];
  assign rt          = instr_r[20:16];
  assign rd          = instr_r[15:11];
  assign shamt       = instr_r[10:6];
  assign func        = instr_r[5:0];
  assign imm         = instr_r[15:0];
  assign jtarget     = instr_r[25:0];

endmodule
